// File: rtl/ahb_imem_responder.sv
// AHB3-Lite instruction-memory slave that serves fetches from a side-loaded program buffer.
// One-cycle read latency; wait states and error responses are driven through HREADYOUT/HRESP.
module ahb_imem_responder #(
  parameter int                    HADDR_SIZE  = 32,
  parameter int                    HDATA_SIZE  = 32,
  parameter int                    DEPTH       = 64,
  parameter logic [HADDR_SIZE-1:0] BASE_ADDR   = 'h200,
  parameter int                    WAIT_STATES = 0,
  parameter logic [HDATA_SIZE-1:0] NOP_INSN    = 'h13,
  localparam int                   IDXW        = $clog2(DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [3:0]            extra_wait_i,
  input  logic                  prog_we_i,
  input  logic [IDXW-1:0]       prog_idx_i,
  input  logic [31:0]           prog_data_i,
  output logic [15:0]           fetch_cnt_o
);

  localparam logic [HADDR_SIZE-1:0] END_ADDR = BASE_ADDR + HADDR_SIZE'(4 * DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state_q;
  logic [HDATA_SIZE-1:0] mem_q [DEPTH];
  logic [HDATA_SIZE-1:0] hrdata_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [15:0]           fetch_cnt_q;
  logic [IDXW-1:0]       idx_q;
  logic [4:0]            wcnt_q;

  logic                  accept;
  logic                  acc_err;
  logic [HADDR_SIZE-1:0] offset;
  logic [IDXW-1:0]       acc_idx;
  logic [4:0]            acc_wait;
  logic                  unused_inputs;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign acc_err  = HWRITE | (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) |
                    (HADDR < BASE_ADDR) | (HADDR >= END_ADDR);
  assign offset   = HADDR - BASE_ADDR;
  // Out-of-range addresses never reach DATA, so truncating the offset is safe.
  assign acc_idx  = offset[IDXW+1:2];
  assign acc_wait = 5'(WAIT_STATES) + {1'b0, extra_wait_i};

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HWDATA, HTRANS[0],
                           offset[HADDR_SIZE-1:IDXW+2], offset[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_INSN;
    end else if (prog_we_i) begin
      mem_q[prog_idx_i] <= prog_data_i;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      fetch_cnt_q <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
    end else begin
      if (state_q == S_DATA && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      case (state_q)
        S_WAIT: begin
          wcnt_q <= wcnt_q - 5'd1;
          if (wcnt_q == 5'd1) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            hrdata_q    <= mem_q[idx_q];
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all complete a beat, so a pipelined accept is taken here.
          if (accept) begin
            idx_q  <= acc_idx;
            wcnt_q <= acc_wait;
            if (acc_err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (acc_wait == 5'd0) begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              hrdata_q    <= mem_q[acc_idx];
            end else begin
              state_q     <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HRDATA      = hrdata_q;
  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_ahb_imem_responder.sv
// Directed bench for ahb_imem_responder with a single slave, so HREADY is HREADYOUT.
module tb_ahb_imem_responder;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  extra_wait_i;
  logic        prog_we_i;
  logic [5:0]  prog_idx_i;
  logic [31:0] prog_data_i;
  logic [15:0] fetch_cnt_o;

  int errors = 0;
  int checks = 0;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_imem_responder dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .extra_wait_i(extra_wait_i),
    .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i), .prog_data_i(prog_data_i),
    .fetch_cnt_o(fetch_cnt_o)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = 3'b010;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  logic [31:0] err_addr [3];
  logic        err_wr   [3];

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HBURST = '0; HPROT = '0; HTRANS = 2'b00; HMASTLOCK = 1'b0; HWDATA = '0;
    extra_wait_i = '0; prog_we_i = 1'b0; prog_idx_i = '0; prog_data_i = '0;
    err_addr[0] = 32'h1FC; err_wr[0] = 1'b0;
    err_addr[1] = 32'h300; err_wr[1] = 1'b0;
    err_addr[2] = 32'h200; err_wr[2] = 1'b1;

    tick(); tick();
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_fetch_cnt", 32'(fetch_cnt_o), 32'd0);
    HRESET = 1'b0;

    // Back-to-back zero-wait reads of reset contents.
    addr_phase(32'h200, 1'b0); tick();
    chk("rd200_data", HRDATA, 32'h13);
    chk("rd200_rdy", 32'(HREADYOUT), 32'd1);
    addr_phase(32'h204, 1'b0); tick();
    chk("rd204_data", HRDATA, 32'h13);
    chk("rd204_rdy", 32'(HREADYOUT), 32'd1);
    addr_phase(32'h208, 1'b0); tick();
    chk("rd208_data", HRDATA, 32'h13);
    chk("rd208_rdy", 32'(HREADYOUT), 32'd1);
    bus_idle(); tick();
    chk("fetch_cnt_3", 32'(fetch_cnt_o), 32'd3);

    // Load two words, then read them back.
    prog_we_i = 1'b1; prog_idx_i = 6'd0; prog_data_i = 32'h00500093; tick();
    prog_idx_i = 6'd1; prog_data_i = 32'h0000006F; tick();
    prog_we_i = 1'b0;
    addr_phase(32'h200, 1'b0); tick();
    chk("prog_rd0", HRDATA, 32'h00500093);
    addr_phase(32'h204, 1'b0); tick();
    chk("prog_rd1", HRDATA, 32'h0000006F);
    bus_idle(); tick();
    chk("fetch_cnt_5", 32'(fetch_cnt_o), 32'd5);

    // Three extra wait cycles.
    extra_wait_i = 4'd3;
    addr_phase(32'h204, 1'b0); tick();
    chk("wait1_rdy", 32'(HREADYOUT), 32'd0);
    bus_idle(); extra_wait_i = 4'd0; tick();
    chk("wait2_rdy", 32'(HREADYOUT), 32'd0);
    tick();
    chk("wait3_rdy", 32'(HREADYOUT), 32'd0);
    tick();
    chk("wait_done_rdy", 32'(HREADYOUT), 32'd1);
    chk("wait_done_resp", 32'(HRESP), 32'd0);
    chk("wait_done_data", HRDATA, 32'h0000006F);
    tick();
    chk("fetch_cnt_6", 32'(fetch_cnt_o), 32'd6);

    // Two-cycle error responses for out-of-range and write transfers.
    for (int i = 0; i < 3; i++) begin
      addr_phase(err_addr[i], err_wr[i]); tick();
      chk($sformatf("err%0d_c1_rdy", i), 32'(HREADYOUT), 32'd0);
      chk($sformatf("err%0d_c1_resp", i), 32'(HRESP), 32'd1);
      bus_idle(); tick();
      chk($sformatf("err%0d_c2_rdy", i), 32'(HREADYOUT), 32'd1);
      chk($sformatf("err%0d_c2_resp", i), 32'(HRESP), 32'd1);
      tick();
      chk($sformatf("err%0d_idle_resp", i), 32'(HRESP), 32'd0);
      chk($sformatf("err%0d_fetch_cnt", i), 32'(fetch_cnt_o), 32'd6);
    end

    // Program write during the DATA cycle of the same word returns the old word.
    addr_phase(32'h208, 1'b0); tick();
    prog_we_i = 1'b1; prog_idx_i = 6'd2; prog_data_i = 32'hDEADBEEF;
    bus_idle();
    chk("wr_same_cycle_old", HRDATA, 32'h13);
    tick();
    prog_we_i = 1'b0;
    addr_phase(32'h208, 1'b0); tick();
    chk("wr_reread_new", HRDATA, 32'hDEADBEEF);
    bus_idle(); tick();
    chk("fetch_cnt_8", 32'(fetch_cnt_o), 32'd8);

    // Reset in the middle of a wait-stated transfer.
    extra_wait_i = 4'd2;
    addr_phase(32'h200, 1'b0); tick();
    chk("rstwait_rdy", 32'(HREADYOUT), 32'd0);
    HRESET = 1'b1; bus_idle(); extra_wait_i = 4'd0; tick();
    chk("rstwait_after_rdy", 32'(HREADYOUT), 32'd1);
    chk("rstwait_after_resp", 32'(HRESP), 32'd0);
    chk("rstwait_after_cnt", 32'(fetch_cnt_o), 32'd0);
    HRESET = 1'b0;
    addr_phase(32'h208, 1'b0); tick();
    chk("rst_mem_208", HRDATA, 32'h13);
    addr_phase(32'h200, 1'b0); tick();
    chk("rst_mem_200", HRDATA, 32'h13);
    bus_idle(); tick();
    chk("fetch_cnt_2", 32'(fetch_cnt_o), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
